load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Parametrised load/store unit for the multicycle core. Replaces the single-cycle word-only data path to
//  the unified memory. Adds byte/half/word(/double) access, byte enables, sign/zero extension and a
//  valid/ready request channel. Bus side is grant/response with variable latency, misalign/illegal
//  detection and a timeout. Sits between ControlFSM/datapath (core side) and the memory bus.
// PARAMETERS
//  XLEN     32   data width, 32 or 64; bus lanes = XLEN/8, OFFW = $clog2(XLEN/8)
//  ADDR_W   32   byte address width
//  TIMEOUT  255  max cycles in ISSUE+WAIT before abort; 0 disables timeout
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  req_valid    in   1       core request present
//  req_ready    out  1       LSU can accept (high only in IDLE)
//  req_we       in   1       1 = store, 0 = load
//  req_funct3   in   3       RISC-V funct3: 000 B,001 H,010 W,011 D,100 BU,101 HU,110 WU
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   XLEN    store data, right-aligned
//  rsp_valid    out  1       one-cycle completion pulse, no backpressure
//  rsp_rdata    out  XLEN    extended load data; 0 for stores and errors
//  rsp_err      out  2       lsu_err_t: 00 OK, 01 MISALIGNED, 10 ILLEGAL, 11 TIMEOUT
//  bus_req      out  1       bus request, held until bus_gnt
//  bus_we       out  1       bus write
//  bus_addr     out  ADDR_W  lane-aligned address (low OFFW bits zero)
//  bus_wdata    out  XLEN    lane-replicated store data
//  bus_be       out  XLEN/8  byte enables (all ones for loads)
//  bus_gnt      in   1       bus accepted request this cycle
//  bus_rvalid   in   1       read data / write ack valid
//  bus_rdata    in   XLEN    read data, full lane word
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, timeout counter 0. All outputs 0 except req_ready=1.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE. Handshake fires on req_valid&&req_ready (IDLE only).
//    Request fields are captured into registers at the handshake.
//  - IDLE: on handshake, illegal funct3 (111; 011/110 when XLEN=32; 100..110 with req_we=1)
//    -> RESP with ILLEGAL. Misaligned (H: a[0]!=0; W: a[1:0]!=0; D: a[2:0]!=0) -> RESP with MISALIGNED.
//    Errored requests make no bus access. Otherwise -> ISSUE.
//  - ISSUE: bus_req=1 with addr/we/wdata/be stable until bus_gnt.
//    gnt&&rvalid in the same cycle -> RESP; gnt alone -> WAIT.
//  - WAIT: bus_req=0; on bus_rvalid, load data is latched, then -> RESP. Writes also wait for rvalid (ack).
//  - RESP: rsp_valid=1 for exactly one cycle -> IDLE; req_ready returns the following cycle.
//  - Latency: zero-wait bus (gnt+rvalid in ISSUE) gives rsp_valid 2 cycles after the handshake;
//    error responses arrive 1 cycle after the handshake.
//  - Timeout: counter clears on entering ISSUE and increments each ISSUE/WAIT cycle.
//    When it equals TIMEOUT: bus_req drops and the FSM -> RESP with TIMEOUT, rdata 0.
//    rvalid in that same cycle wins (normal completion).
//  - bus_rvalid outside WAIT/ISSUE-with-gnt is ignored, including stale responses after a reset or timeout.
//  - Store lanes: off=addr[OFFW-1:0]; B data replicated per byte, be=1<<off; H replicated per half,
//    be=2'b11<<off; W/D likewise. bus_addr = {addr[ADDR_W-1:OFFW], OFFW'b0}.
//  - Load: shift = bus_rdata >> (8*off); B/H/W sign-extended from bit 7/15/31; BU/HU/WU zero-extended;
//    D passed through.
//  - Reset mid-transaction aborts immediately; no rsp_valid is produced for the aborted request.
// STRUCTURE
//  - src/types.svh gains: lsu_state_t (LSU_STATE__IDLE/ISSUE/WAIT/RESP), lsu_err_t (LSU_ERR__*),
//    LSU_F3__LB..LSU_F3__LWU constants.
//  - Sub-module lsu_align (combinational, XLEN param): store lane replication, byte-enable generation,
//    load extraction and extension, misalign/illegal decode. FSM, capture registers and counter live in
//    load_store_unit.
// TESTING
//  1 SB a=0x103 d=0xA5, zero-wait bus -> bus_be=4'b1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100,
//    rsp_valid 2 cycles after the handshake, rsp_err=00.
//  2 LH a=0x202, rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; LHU on the same access -> 0x00008001.
//  3 LW a=0x105 -> rsp_err=01 one cycle after the handshake, bus_req never asserted.
//  4 Slow bus: gnt after 3 cycles, rvalid 5 cycles later -> bus_req high exactly 4 cycles,
//    one rsp_valid, req_ready low throughout.
//  5 TIMEOUT=8, bus never grants -> bus_req drops and rsp_err=11 on the 9th cycle after the handshake;
//    a later rvalid is ignored.
//  6 Assert reset in WAIT -> outputs cleared asynchronously, no rsp_valid; a following LW a=0x0
//    completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, error codes
// and RISC-V load/store funct3 encodings.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_STATE__IDLE  = 2'd0,
        LSU_STATE__ISSUE = 2'd1,
        LSU_STATE__WAIT  = 2'd2,
        LSU_STATE__RESP  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        LSU_ERR__OK         = 2'b00,
        LSU_ERR__MISALIGNED = 2'b01,
        LSU_ERR__ILLEGAL    = 2'b10,
        LSU_ERR__TIMEOUT    = 2'b11
    } lsu_err_t;

    localparam logic [2:0] LSU_F3__LB  = 3'b000;
    localparam logic [2:0] LSU_F3__LH  = 3'b001;
    localparam logic [2:0] LSU_F3__LW  = 3'b010;
    localparam logic [2:0] LSU_F3__LD  = 3'b011;
    localparam logic [2:0] LSU_F3__LBU = 3'b100;
    localparam logic [2:0] LSU_F3__LHU = 3'b101;
    localparam logic [2:0] LSU_F3__LWU = 3'b110;

    // Access size in bytes; the low two funct3 bits encode log2(size).
    function automatic int access_bytes(input logic [2:0] funct3);
        return 1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store replication and byte enables, load
// extraction with sign/zero extension, and illegal/misaligned decode.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = XLEN / 8,
    parameter int OFFW  = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3,
    input  logic             we,
    input  logic [2:0]       addr_lo,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  lane_wdata,
    output logic [LANES-1:0] lane_be,
    output logic             illegal,
    output logic             misaligned,
    input  logic [2:0]       ld_funct3,
    input  logic [OFFW-1:0]  ld_off,
    input  logic [XLEN-1:0]  ld_rdata,
    output logic [XLEN-1:0]  ld_data
);

    logic [XLEN-1:0] shifted;
    int              size;
    int              off;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lane_wdata = '0;
        lane_be    = '0;
        size       = access_bytes(funct3);
        off        = int'(addr_lo[OFFW-1:0]);
        for (int i = 0; i < LANES; i++) begin
            lane_wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
            lane_be[i]           = (i >= off) && (i < off + size);
        end
    end

    // Unsigned variants cannot be stored; D/WU need a 64-bit data path.
    always_comb begin
        illegal = (funct3 == 3'b111) || (we && funct3[2]) ||
                  ((XLEN == 32) && ((funct3 == LSU_F3__LD) || (funct3 == LSU_F3__LWU)));
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo[1:0];
            2'b11:   misaligned = |addr_lo[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        shifted = ld_rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            LSU_F3__LB:  ld_data = XLEN'($signed(shifted[7:0]));
            LSU_F3__LH:  ld_data = XLEN'($signed(shifted[15:0]));
            LSU_F3__LW:  ld_data = XLEN'($signed(shifted[31:0]));
            LSU_F3__LBU: ld_data = XLEN'(shifted[7:0]);
            LSU_F3__LHU: ld_data = XLEN'(shifted[15:0]);
            LSU_F3__LWU: ld_data = XLEN'(shifted[31:0]);
            LSU_F3__LD:  ld_data = shifted;
            default:     ld_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready core request channel to a grant/response memory
// bus with variable latency, access checks and a transaction timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_be,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [XLEN-1:0]     bus_rdata
);

    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [OFFW-1:0]   off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [LANES-1:0]  be_q;
    logic [XLEN-1:0]   rdata_q;
    lsu_err_t          err_q;

    logic              handshake;
    logic              timeout_hit;
    logic              complete;
    logic              abort;
    logic              dec_illegal;
    logic              dec_misaligned;
    logic [XLEN-1:0]   lane_wdata;
    logic [LANES-1:0]  lane_be;
    logic [XLEN-1:0]   ld_data;

    assign handshake = req_valid && (state == LSU_STATE__IDLE);
    // Abort on the last allowed ISSUE/WAIT cycle so at most TIMEOUT cycles are spent on the bus.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (req_funct3),
        .we         (req_we),
        .addr_lo    (req_addr[2:0]),
        .wdata      (req_wdata),
        .lane_wdata (lane_wdata),
        .lane_be    (lane_be),
        .illegal    (dec_illegal),
        .misaligned (dec_misaligned),
        .ld_funct3  (funct3_q),
        .ld_off     (off_q),
        .ld_rdata   (bus_rdata),
        .ld_data    (ld_data)
    );

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            LSU_STATE__IDLE: begin
                if (handshake)
                    state_next = (dec_illegal || dec_misaligned) ? LSU_STATE__RESP : LSU_STATE__ISSUE;
            end
            LSU_STATE__ISSUE: begin
                if (bus_gnt && bus_rvalid) begin
                    complete   = 1'b1;
                    state_next = LSU_STATE__RESP;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = LSU_STATE__RESP;
                end else if (bus_gnt) begin
                    state_next = LSU_STATE__WAIT;
                end
            end
            LSU_STATE__WAIT: begin
                if (bus_rvalid) begin
                    complete   = 1'b1;
                    state_next = LSU_STATE__RESP;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = LSU_STATE__RESP;
                end
            end
            LSU_STATE__RESP: state_next = LSU_STATE__IDLE;
            default:         state_next = LSU_STATE__IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LSU_STATE__IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (handshake)
            cnt <= '0;
        else if ((state == LSU_STATE__ISSUE) || (state == LSU_STATE__WAIT))
            cnt <= cnt + 1'b1;
    end

    // NOTE: capture registers are reset too, so an abort mid-transaction leaves no stale request behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            err_q    <= LSU_ERR__OK;
        end else begin
            if (handshake) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                off_q    <= req_addr[OFFW-1:0];
                addr_q   <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                wdata_q  <= req_we ? lane_wdata : '0;
                be_q     <= req_we ? lane_be : '1;
                rdata_q  <= '0;
                err_q    <= dec_illegal    ? LSU_ERR__ILLEGAL :
                            dec_misaligned ? LSU_ERR__MISALIGNED : LSU_ERR__OK;
            end
            if (complete && !we_q)
                rdata_q <= ld_data;
            if (abort)
                err_q <= LSU_ERR__TIMEOUT;
        end
    end

    assign req_ready = (state == LSU_STATE__IDLE);
    assign bus_req   = (state == LSU_STATE__ISSUE);
    assign bus_we    = bus_req && we_q;
    assign bus_addr  = bus_req ? addr_q  : '0;
    assign bus_wdata = bus_req ? wdata_q : '0;
    assign bus_be    = bus_req ? be_q    : '0;
    assign rsp_valid = (state == LSU_STATE__RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid ? err_q : LSU_ERR__OK;

endmodule
